// File: rtl/or_gate_unit_if.sv
// or_gate_unit_if: operand, control and result bundle for or_gate_unit.
interface or_gate_unit_if #(parameter int W = 1);
  localparam int CW = ($clog2(W + 1) < 1) ? 1 : $clog2(W + 1);
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic          clear;
  logic [W-1:0]  y;
  logic [W-1:0]  y_q;
  logic          out_valid;
  logic          any_q;
  logic [CW-1:0] ones_q;
  logic [W-1:0]  sticky_q;
  modport master (output a, b, in_valid, clear,
                  input  y, y_q, out_valid, any_q, ones_q, sticky_q);
  modport slave  (input  a, b, in_valid, clear,
                  output y, y_q, out_valid, any_q, ones_q, sticky_q);
endinterface

// File: rtl/or_gate_unit.sv
// or_gate_unit: combinational a|b plus registered result, reduction, popcount and sticky accumulator.
module or_gate_unit #(parameter int W = 1) (
  input logic          clk,
  input logic          rst_n,
  or_gate_unit_if.slave bus
);
  localparam int CW = ($clog2(W + 1) < 1) ? 1 : $clog2(W + 1);
  logic [W-1:0]  v;
  logic [CW-1:0] cnt;
  assign v     = bus.a | bus.b;
  assign bus.y = v;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + CW'(v[i]);
  end
  // clear drops history but a simultaneous valid sample still lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.y_q       <= '0;
      bus.any_q     <= 1'b0;
      bus.ones_q    <= '0;
      bus.out_valid <= 1'b0;
      bus.sticky_q  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.y_q    <= v;
        bus.any_q  <= |v;
        bus.ones_q <= cnt;
      end
      bus.sticky_q <= bus.clear ? (bus.in_valid ? v : '0)
                                : (bus.in_valid ? bus.sticky_q | v : bus.sticky_q);
    end
  end
endmodule

// File: tb/tb_or_gate_unit.sv
// tb_or_gate_unit: directed vectors on W=1 and W=8 instances against a per-cycle reference model.
module tb_or_gate_unit;
  logic clk = 1'b0;
  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic rst1_n = 1'b0;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  or_gate_unit_if #(.W(1)) i1 ();
  or_gate_unit_if #(.W(8)) i8 ();
  or_gate_unit #(.W(1)) u1 (.clk(clk1), .rst_n(rst1_n), .bus(i1.slave));
  or_gate_unit #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: what the registered outputs must be after each edge
  logic [7:0] m_yq = 0, m_sticky = 0;
  logic       m_any = 0, m_vld = 0;
  int         m_ones = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq = 0; m_any = 0; m_ones = 0; m_vld = 0; m_sticky = 0;
    end else begin
      m_vld = i8.in_valid;
      if (i8.in_valid) begin
        m_yq   = i8.a | i8.b;
        m_any  = (i8.a | i8.b) != 0;
        m_ones = $countones(i8.a | i8.b);
      end
      if (i8.clear) m_sticky = i8.in_valid ? (i8.a | i8.b) : 8'h00;
      else if (i8.in_valid) m_sticky = m_sticky | i8.a | i8.b;
    end
    #1;
    if (chk_en) begin
      check("mdl_y", 64'(i8.y), 64'(i8.a | i8.b));
      check("mdl_y_q", 64'(i8.y_q), 64'(m_yq));
      check("mdl_any_q", 64'(i8.any_q), 64'(m_any));
      check("mdl_ones_q", 64'(i8.ones_q), 64'(m_ones));
      check("mdl_out_valid", 64'(i8.out_valid), 64'(m_vld));
      check("mdl_sticky_q", 64'(i8.sticky_q), 64'(m_sticky));
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
    @(negedge clk);
    i8.a = a; i8.b = b; i8.in_valid = v; i8.clear = c;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] ab;
    i1.a = 0; i1.b = 0; i1.in_valid = 0; i1.clear = 0;
    i8.a = 0; i8.b = 0; i8.in_valid = 0; i8.clear = 0;
    $display("a b | y");
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      i1.a = ab[1]; i1.b = ab[0];
      #5;
      $display("%b %b | %b", i1.a, i1.b, i1.y);
      check("tt_y", 64'(i1.y), (i == 0) ? 64'd0 : 64'd1);
      #5;
    end
    check("w1_rst_y_q", 64'(i1.y_q), 64'd0);
    check("w1_rst_sticky", 64'(i1.sticky_q), 64'd0);
    @(negedge clk);
    check("rst_y_q", 64'(i8.y_q), 64'd0);
    check("rst_ov", 64'(i8.out_valid), 64'd0);
    check("rst_ones", 64'(i8.ones_q), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    drive(8'hA5, 8'h0F, 1, 0);
    #1 check("wid_y_comb", 64'(i8.y), 64'hAF);
    after_edge();
    check("wid_y_q", 64'(i8.y_q), 64'hAF);
    check("wid_any", 64'(i8.any_q), 64'd1);
    check("wid_ones", 64'(i8.ones_q), 64'd6);
    check("wid_ov", 64'(i8.out_valid), 64'd1);
    drive(8'h00, 8'h00, 0, 0);
    after_edge();
    check("wid_ov_drop", 64'(i8.out_valid), 64'd0);
    check("wid_hold", 64'(i8.y_q), 64'hAF);
    drive(8'h00, 8'h00, 1, 0);
    after_edge();
    check("zero_y_q", 64'(i8.y_q), 64'd0);
    check("zero_any", 64'(i8.any_q), 64'd0);
    check("zero_ones", 64'(i8.ones_q), 64'd0);
    check("zero_ov", 64'(i8.out_valid), 64'd1);
    drive(8'h00, 8'h00, 0, 1);
    after_edge();
    check("stk_pre_clear", 64'(i8.sticky_q), 64'd0);
    drive(8'h01, 8'h00, 1, 0);
    drive(8'h10, 8'h00, 1, 0);
    drive(8'h80, 8'h00, 1, 0);
    after_edge();
    check("stk_acc", 64'(i8.sticky_q), 64'h91);
    check("b2b_ov", 64'(i8.out_valid), 64'd1);
    drive(8'h02, 8'h00, 1, 1);
    after_edge();
    check("stk_clr_valid", 64'(i8.sticky_q), 64'h02);
    drive(8'h00, 8'h00, 0, 1);
    after_edge();
    check("stk_clr", 64'(i8.sticky_q), 64'h00);
    drive(8'h55, 8'h00, 0, 0);
    drive(8'hAA, 8'h01, 0, 0);
    drive(8'h0F, 8'hF0, 0, 0);
    after_edge();
    check("hold_y", 64'(i8.y), 64'hFF);
    check("hold_y_q", 64'(i8.y_q), 64'h02);
    check("hold_ones", 64'(i8.ones_q), 64'd1);
    check("hold_ov", 64'(i8.out_valid), 64'd0);
    drive(8'hFF, 8'h00, 1, 0);
    after_edge();
    check("pre_rst_y_q", 64'(i8.y_q), 64'hFF);
    check("pre_rst_ones", 64'(i8.ones_q), 64'd8);
    i8.a = 8'h3C; i8.b = 8'h41;
    rst_n = 1'b0;
    #1;
    check("arst_y_q", 64'(i8.y_q), 64'd0);
    check("arst_any", 64'(i8.any_q), 64'd0);
    check("arst_ones", 64'(i8.ones_q), 64'd0);
    check("arst_ov", 64'(i8.out_valid), 64'd0);
    check("arst_sticky", 64'(i8.sticky_q), 64'd0);
    check("arst_y", 64'(i8.y), 64'h7D);
    after_edge();
    check("arst_no_ov", 64'(i8.out_valid), 64'd0);
    @(negedge clk);
    i8.in_valid = 0;
    rst_n = 1'b1;
    after_edge();
    check("post_rst_ov", 64'(i8.out_valid), 64'd0);
    check("post_rst_y_q", 64'(i8.y_q), 64'd0);
    drive(8'h0C, 8'h30, 1, 0);
    after_edge();
    check("post_rst_cap", 64'(i8.y_q), 64'h3C);
    check("post_rst_ones", 64'(i8.ones_q), 64'd4);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
